// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage SRAM controller.
//   - FSM state encoding
//   - default SRAM window base address and strobe hold time
//   - counter width and the byte-to-word address helper
package mem_stage_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_WAIT_CYCLES = 5;
    // WAIT_CYCLES tops out at 15, so the counter only ever holds 0..14.
    localparam int          CNT_W           = 4;

    // Byte address relative to the SRAM window, in words. Bits [1:0] are
    // dropped and anything below the base simply wraps.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                                 input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Down-counter timing how long the SRAM strobes stay asserted.
//   i_clk, i_rst_n : clock, async active-low reset (count clears to 0)
//   i_load         : load i_load_val (has priority over i_en)
//   i_load_val     : value loaded at the start of an access
//   i_en           : decrement; the count stops at zero rather than wrapping
//   o_zero         : count is zero
module sram_wait_counter
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: turns an execute-stage load/store into a
// multi-cycle single-word access on an external synchronous SRAM, freezing
// the upstream pipeline until the access completes.
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_mem_read, i_mem_write  : load / store request (store wins if both)
//   i_alu_result             : byte address
//   i_val_rm                 : store data
//   o_freeze                 : hold IF/ID/EXE (combinational)
//   o_ready                  : one-cycle completion pulse (registered)
//   o_mem_rdata              : load data, held until the next load
//   o_sram_addr/o_sram_wdata : registered SRAM word address / write data
//   i_sram_rdata             : SRAM read data
//   o_sram_ce_n/we_n/oe_n    : active-low SRAM strobes
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = 17,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [31:0]       i_alu_result,
    input  logic [31:0]       i_val_rm,
    output logic              o_freeze,
    output logic              o_ready,
    output logic [31:0]       o_mem_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [31:0]       o_sram_wdata,
    input  logic [31:0]       i_sram_rdata,
    output logic              o_sram_ce_n,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_is_store;
    logic                r_ready;
    logic [31:0]         r_mem_rdata;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [31:0]         r_sram_wdata;

    logic                w_req;
    logic                w_start;
    logic                w_cnt_zero;
    logic                w_last_access;
    logic [ADDR_W-1:0]   w_word;

    assign w_req         = i_mem_read | i_mem_write;
    assign w_start       = (r_state == ST_IDLE) && w_req;
    assign w_last_access = (r_state == ST_ACCESS) && w_cnt_zero;
    assign w_word        = ADDR_W'(byte_to_word(i_alu_result, BASE_ADDR));

    sram_wait_counter #(.W(CNT_W)) u_wait_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_start),
        .i_load_val (LOAD_VAL),
        .i_en       (r_state == ST_ACCESS),
        .o_zero     (w_cnt_zero)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next_state = w_req      ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: w_next_state = w_cnt_zero ? ST_DONE   : ST_ACCESS;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so they drop the
    // instant reset asserts and never depend on live request inputs.
    always_comb begin
        o_sram_ce_n = 1'b1;
        o_sram_we_n = 1'b1;
        o_sram_oe_n = 1'b1;
        if (r_state == ST_ACCESS) begin
            o_sram_ce_n = 1'b0;
            o_sram_we_n = ~r_is_store;
            o_sram_oe_n = r_is_store;
        end
    end

    // Datapath: the request is latched once in IDLE; upstream is frozen
    // afterwards so later input changes are irrelevant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_store   <= 1'b0;
            r_ready      <= 1'b0;
            r_mem_rdata  <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_ready <= w_last_access;
            if (w_start) begin
                r_sram_addr  <= w_word;
                r_sram_wdata <= i_val_rm;
                r_is_store   <= i_mem_write;
            end
            if (w_last_access && !r_is_store) begin
                r_mem_rdata <= i_sram_rdata;
            end
        end
    end

    assign o_ready      = r_ready;
    assign o_freeze     = w_req & ~r_ready;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wdata = r_sram_wdata;

endmodule
